axi_ar_arbiter_ctrl: RTL and testbench

AXI_AR_ARBITER_CTRL -- requirements
Module: axi_ar_arbiter_ctrl

---
 rtl/axi_ar_arbiter_ctrl_if.sv | 25 ++
 rtl/axi_ar_arbiter_ctrl.sv | 129 ++++++++++++
 tb/tb_axi_ar_arbiter_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_ar_arbiter_ctrl_if.sv
// AR bus bundle between N requesters and one initiator AR port.
// Signal suffixes are from the arbiter's point of view.
interface axi_ar_arbiter_ctrl_if #(
    parameter int unsigned N_TARG_PORT = 4,
    parameter int unsigned PAYLOAD_W   = 64
);
    logic [N_TARG_PORT-1:0]                arvalid_i;
    logic [N_TARG_PORT-1:0][PAYLOAD_W-1:0] ardata_i;
    logic [N_TARG_PORT-1:0]                arready_o;
    logic                                  arvalid_o;
    logic [PAYLOAD_W-1:0]                  ardata_o;
    logic                                  arready_i;

    // Arbiter side
    modport slave (
        input  arvalid_i, ardata_i, arready_i,
        output arready_o, arvalid_o, ardata_o
    );

    // Requester / initiator side (driver of the arbiter)
    modport master (
        output arvalid_i, ardata_i, arready_i,
        input  arready_o, arvalid_o, ardata_o
    );
endinterface

// File: rtl/axi_ar_arbiter_ctrl.sv
// Round-robin AR channel arbiter with grant locking until handshake and an
// outstanding-burst counter that throttles new grants.
module axi_ar_arbiter_ctrl #(
    parameter int unsigned N_TARG_PORT = 4,
    parameter int unsigned PAYLOAD_W   = 64,
    parameter int unsigned MAX_OUT     = 4,
    localparam int unsigned IdxW       = $clog2(N_TARG_PORT),
    localparam int unsigned CntW       = $clog2(MAX_OUT + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    axi_ar_arbiter_ctrl_if.slave     bus,
    output logic                     push_o,
    output logic [IdxW-1:0]          push_id_o,
    input  logic                     fifo_full_i,
    input  logic                     rdone_i,
    output logic                     outstanding_o,
    output logic                     full_counter_o
);

    localparam logic [0:0] StArb  = 1'b0;
    localparam logic [0:0] StHold = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [IdxW-1:0]      rr_q, rr_d;
    logic [IdxW-1:0]      lock_q, lock_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 win_found;
    logic [IdxW-1:0]      win_idx;
    logic [IdxW-1:0]      cand;
    logic                 grant_ok;
    logic [PAYLOAD_W-1:0] data_sel;

    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
        if (32'(idx) == N_TARG_PORT - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    assign outstanding_o  = (cnt_q != '0);
    assign full_counter_o = (32'(cnt_q) == MAX_OUT);
    assign grant_ok       = win_found && !fifo_full_i && !full_counter_o;
    assign bus.ardata_o   = data_sel;

    // Round-robin search starting at rr_q, wrapping modulo N_TARG_PORT
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_q;
        cand      = rr_q;
        for (int unsigned i = 0; i < N_TARG_PORT; i++) begin
            if (!win_found && bus.arvalid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
            cand = next_idx(cand);
        end
    end

    // FSM next state, grant outputs and pointer updates
    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        lock_d        = lock_q;
        bus.arvalid_o = 1'b0;
        bus.arready_o = '0;
        push_o        = 1'b0;
        push_id_o     = rr_q;
        data_sel      = bus.ardata_i[rr_q];
        if (!rst) begin
            case (state_q)
                StArb: begin
                    if (grant_ok) begin
                        bus.arvalid_o = 1'b1;
                        data_sel      = bus.ardata_i[win_idx];
                        if (bus.arready_i) begin
                            bus.arready_o[win_idx] = 1'b1;
                            push_o                 = 1'b1;
                            push_id_o              = win_idx;
                            rr_d                   = next_idx(win_idx);
                        end else begin
                            lock_d  = win_idx;
                            state_d = StHold;
                        end
                    end
                end
                StHold: begin
                    // Held grant ignores FIFO/counter state: it was admitted when locked
                    bus.arvalid_o = 1'b1;
                    data_sel      = bus.ardata_i[lock_q];
                    if (bus.arready_i) begin
                        bus.arready_o[lock_q] = 1'b1;
                        push_o                = 1'b1;
                        push_id_o             = lock_q;
                        rr_d                  = next_idx(lock_q);
                        state_d               = StArb;
                    end
                end
                default: state_d = StArb;
            endcase
        end
    end

    // Outstanding counter: simultaneous push and rdone cancel, no underflow
    always_comb begin
        cnt_d = cnt_q;
        if (push_o && !rdone_i) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push_o && rdone_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StArb;
            rr_q    <= '0;
            lock_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_axi_ar_arbiter_ctrl.sv
// Bench for axi_ar_arbiter_ctrl: directed scenarios plus randomized traffic,
// checked against a distance-based round-robin reference model.
module tb_axi_ar_arbiter_ctrl;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int MO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic [1:0] push_id;
    logic       fifo_full;
    logic       rdone;
    logic       outstanding;
    logic       full_ctr;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    bit m_hold;
    int m_rr, m_lock, m_cnt;
    // Reference model expectations
    int         e_sel;
    logic       e_arvalid, e_push, e_out, e_full;
    logic [3:0] e_arready;
    logic [1:0] e_push_id;

    axi_ar_arbiter_ctrl_if #(.N_TARG_PORT(N), .PAYLOAD_W(W)) bus ();

    axi_ar_arbiter_ctrl #(
        .N_TARG_PORT(N),
        .PAYLOAD_W  (W),
        .MAX_OUT    (MO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .push_o        (push),
        .push_id_o     (push_id),
        .fifo_full_i   (fifo_full),
        .rdone_i       (rdone),
        .outstanding_o (outstanding),
        .full_counter_o(full_ctr)
    );

    always #5 clk = ~clk;

    // Expected outputs: winner is the valid requester closest to rr going upward
    task automatic model_comb();
        int bestd;
        e_sel = -1; e_arvalid = 0; e_arready = '0; e_push = 0; e_push_id = '0;
        if (!rst) begin
            if (m_hold) begin
                e_sel = m_lock;
            end else if (bus.arvalid_i != 0 && !fifo_full && m_cnt < MO) begin
                bestd = N;
                for (int i = 0; i < N; i++) begin
                    if (bus.arvalid_i[i] && ((i - m_rr + N) % N) < bestd) begin
                        bestd = (i - m_rr + N) % N;
                        e_sel = i;
                    end
                end
            end
            if (e_sel >= 0) begin
                e_arvalid = 1;
                if (bus.arready_i) begin
                    e_arready[e_sel] = 1'b1;
                    e_push = 1;
                    e_push_id = 2'(e_sel);
                end
            end
        end
        e_out  = (m_cnt != 0);
        e_full = (m_cnt == MO);
    endtask

    task automatic model_clock();
        if (rst) begin
            m_hold = 0; m_rr = 0; m_lock = 0; m_cnt = 0;
        end else begin
            if (e_sel >= 0) begin
                if (bus.arready_i) begin
                    m_hold = 0;
                    m_rr = (e_sel + 1) % N;
                end else begin
                    m_hold = 1;
                    m_lock = e_sel;
                end
            end
            if (e_push && !rdone) m_cnt++;
            else if (!e_push && rdone && m_cnt > 0) m_cnt--;
        end
    endtask

    // Advance one clock; returns at the following falling edge
    task automatic tick();
        model_comb();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic set_data();
        for (int i = 0; i < N; i++) bus.ardata_i[i] = {$urandom(), $urandom()};
    endtask

    task automatic drain();
        bus.arvalid_i = '0; rdone = 1;
        for (int i = 0; i <= MO; i++) tick();
        rdone = 0;
    endtask

    task automatic test_reset();
        rst = 1; bus.arvalid_i = 4'b1111; bus.arready_i = 1; fifo_full = 0; rdone = 0;
        set_data();
        #1;
        vectors++;
        if (bus.arvalid_o !== 1'b0 || bus.arready_o !== 4'b0000 || push !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: arvalid=%b arready=%b push=%b want 0 0000 0",
                     bus.arvalid_o, bus.arready_o, push);
        end
        tick(); tick();
        #1;
        vectors++;
        if (outstanding !== 1'b0 || full_ctr !== 1'b0 || bus.arvalid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: outstanding=%b full=%b arvalid=%b want 0 0 0",
                     outstanding, full_ctr, bus.arvalid_o);
        end
    endtask

    task automatic test_rr_all();
        rst = 0; bus.arvalid_i = 4'b1111; bus.arready_i = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            vectors++;
            if (bus.arvalid_o !== 1'b1 || bus.arready_o !== 4'(1 << k) || push !== 1'b1 ||
                push_id !== 2'(k) || bus.ardata_o !== bus.ardata_i[k]) begin
                miscompares++;
                $display("FAIL rr_all[%0d]: arvalid=%b arready=%b push=%b id=%0d want 1 %b 1 %0d",
                         k, bus.arvalid_o, bus.arready_o, push, push_id, 4'(1 << k), k);
            end
            tick();
        end
        #1;
        vectors++;
        if (full_ctr !== 1'b1 || bus.arvalid_o !== 1'b0 || push !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_full: full=%b arvalid=%b push=%b want 1 0 0",
                     full_ctr, bus.arvalid_o, push);
        end
        drain();
    endtask

    task automatic test_hold();
        bus.arvalid_i = 4'b0100; bus.arready_i = 0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) bus.arvalid_i = 4'b0101;
            #1;
            vectors++;
            if (bus.arvalid_o !== 1'b1 || bus.ardata_o !== bus.ardata_i[2] ||
                bus.arready_o !== 4'b0000 || push !== 1'b0) begin
                miscompares++;
                $display("FAIL hold[%0d]: arvalid=%b data=%h arready=%b push=%b want 1 %h 0000 0",
                         c, bus.arvalid_o, bus.ardata_o, bus.arready_o, push, bus.ardata_i[2]);
            end
            tick();
        end
        bus.arready_i = 1;
        #1;
        vectors++;
        if (bus.arready_o !== 4'b0100 || push !== 1'b1 || push_id !== 2'd2) begin
            miscompares++;
            $display("FAIL hold_release: arready=%b push=%b id=%0d want 0100 1 2",
                     bus.arready_o, push, push_id);
        end
        tick();
    endtask

    task automatic test_wrap();
        bus.arvalid_i = 4'b1001; bus.arready_i = 1;
        #1;
        vectors++;
        if (push !== 1'b1 || push_id !== 2'd3 || bus.arready_o !== 4'b1000) begin
            miscompares++;
            $display("FAIL wrap_first: push=%b id=%0d arready=%b want 1 3 1000",
                     push, push_id, bus.arready_o);
        end
        tick();
        #1;
        vectors++;
        if (push !== 1'b1 || push_id !== 2'd0 || bus.arready_o !== 4'b0001) begin
            miscompares++;
            $display("FAIL wrap_second: push=%b id=%0d arready=%b want 1 0 0001",
                     push, push_id, bus.arready_o);
        end
        tick();
        drain();
    endtask

    task automatic test_fifo_full();
        bus.arvalid_i = 4'b0010; bus.arready_i = 1; fifo_full = 1;
        #1;
        vectors++;
        if (bus.arvalid_o !== 1'b0 || push !== 1'b0 || bus.arready_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL fifo_full_block: arvalid=%b push=%b arready=%b want 0 0 0000",
                     bus.arvalid_o, push, bus.arready_o);
        end
        tick();
        fifo_full = 0;
        #1;
        vectors++;
        if (bus.arvalid_o !== 1'b1 || push !== 1'b1 || push_id !== 2'd1 ||
            bus.arready_o !== 4'b0010) begin
            miscompares++;
            $display("FAIL fifo_full_release: arvalid=%b push=%b id=%0d arready=%b want 1 1 1 0010",
                     bus.arvalid_o, push, push_id, bus.arready_o);
        end
        tick();
    endtask

    task automatic test_counter();
        logic [3:0] want;
        drain();
        bus.arvalid_i = 4'b0001; bus.arready_i = 1;
        tick(); tick();
        rdone = 1;               // handshake and rdone together: count holds at 2
        tick();
        bus.arvalid_i = '0;
        want = 4'b1100;          // outstanding expected: 1,1,0,0 over next four cycles
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                rdone = 0; bus.arvalid_i = 4'b0001;
            end
            #1;
            vectors++;
            if (outstanding !== want[3 - c]) begin
                miscompares++;
                $display("FAIL counter[%0d]: outstanding=%b want %b", c, outstanding, want[3 - c]);
            end
            tick();
        end
        bus.arvalid_i = '0;
        #1;
        vectors++;
        if (outstanding !== 1'b1 || full_ctr !== 1'b0) begin
            miscompares++;
            $display("FAIL counter_no_underflow: outstanding=%b full=%b want 1 0",
                     outstanding, full_ctr);
        end
    endtask

    task automatic test_reset_hold();
        bus.arvalid_i = 4'b0100; bus.arready_i = 0;
        tick();
        rst = 1; bus.arready_i = 1;
        #1;
        vectors++;
        if (push !== 1'b0 || bus.arvalid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold_push: push=%b arvalid=%b want 0 0", push, bus.arvalid_o);
        end
        tick();
        rst = 0; bus.arready_i = 0; bus.arvalid_i = '0;
        #1;
        vectors++;
        if (bus.arvalid_o !== 1'b0 || outstanding !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold_state: arvalid=%b outstanding=%b want 0 0",
                     bus.arvalid_o, outstanding);
        end
        tick();
        bus.arvalid_i = 4'b1111;
        #1;
        vectors++;
        if (bus.arvalid_o !== 1'b1 || bus.ardata_o !== bus.ardata_i[0]) begin
            miscompares++;
            $display("FAIL reset_hold_rr: arvalid=%b data=%h want 1 %h",
                     bus.arvalid_o, bus.ardata_o, bus.ardata_i[0]);
        end
        tick();
        bus.arready_i = 1;
        #1;
        vectors++;
        if (push !== 1'b1 || push_id !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_hold_grant: push=%b id=%0d want 1 0", push, push_id);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            bus.arvalid_i = 4'($urandom());
            bus.arready_i = ($urandom_range(0, 2) != 0);
            fifo_full     = ($urandom_range(0, 4) == 0);
            rdone         = ($urandom_range(0, 2) == 0);
            rst           = ($urandom_range(0, 49) == 0);
            if (m_hold) bus.arvalid_i[m_lock] = 1'b1;
            set_data();
            #1;
            model_comb();
            vectors++;
            if (bus.arvalid_o !== e_arvalid || bus.arready_o !== e_arready || push !== e_push ||
                outstanding !== e_out || full_ctr !== e_full ||
                (e_push && push_id !== e_push_id) ||
                (e_arvalid && bus.ardata_o !== bus.ardata_i[e_sel])) begin
                miscompares++;
                $display("FAIL random[%0d]: arvalid=%b arready=%b push=%b id=%0d out=%b full=%b want %b %b %b %0d %b %b",
                         c, bus.arvalid_o, bus.arready_o, push, push_id, outstanding, full_ctr,
                         e_arvalid, e_arready, e_push, e_push_id, e_out, e_full);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1; fifo_full = 0; rdone = 0;
        bus.arvalid_i = '0; bus.arready_i = 0; bus.ardata_i = '0;
        m_hold = 0; m_rr = 0; m_lock = 0; m_cnt = 0;
        @(negedge clk);
        test_reset();
        test_rr_all();
        test_hold();
        test_wrap();
        test_fifo_full();
        test_counter();
        test_reset_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
